// File: rtl/sort4_collector.sv
// rtl/sort4_collector.sv - collects four 4-bit samples into one frame for the sort4 network
// Optional SORT4_DBUF_EN: separate assembly buffer so collection continues while a frame is held.
module sort4_collector (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [1:0] cnt
);

  logic accept;

  assign accept = in_valid && in_ready;

`ifdef SORT4_DBUF_EN

  logic       handoff;
  logic       asm_full;
  logic [3:0] asm0, asm1, asm2, asm3;

  assign handoff  = out_valid && out_ready;
  assign in_ready = !asm_full && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      cnt       <= 2'd0;
      asm_full  <= 1'b0;
      a <= 4'd0; b <= 4'd0; c <= 4'd0; d <= 4'd0;
      asm0 <= 4'd0; asm1 <= 4'd0; asm2 <= 4'd0; asm3 <= 4'd0;
    end else begin
      // A waiting assembled frame replaces the one being handed off unless clr discards it.
      if (handoff) begin
        if (asm_full && !clr) begin
          a <= asm0; b <= asm1; c <= asm2; d <= asm3;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (clr) begin
        cnt      <= 2'd0;
        asm_full <= 1'b0;
      end else if (accept) begin
        cnt <= cnt + 2'd1;
        case (cnt)
          2'd0: asm0 <= in_data;
          2'd1: asm1 <= in_data;
          2'd2: asm2 <= in_data;
          default: begin
            if (!out_valid || handoff) begin
              a <= asm0; b <= asm1; c <= asm2; d <= in_data;
              out_valid <= 1'b1;
            end else begin
              asm3     <= in_data;
              asm_full <= 1'b1;
            end
          end
        endcase
      end else if (handoff && asm_full) begin
        asm_full <= 1'b0;
      end
    end
  end

`else

  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state;

  assign in_ready = (state == COLLECT) && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      out_valid <= 1'b0;
      cnt       <= 2'd0;
      a <= 4'd0; b <= 4'd0; c <= 4'd0; d <= 4'd0;
    end else begin
      case (state)
        COLLECT: begin
          if (clr) begin
            cnt <= 2'd0;
          end else if (accept) begin
            cnt <= cnt + 2'd1;
            case (cnt)
              2'd0: a <= in_data;
              2'd1: b <= in_data;
              2'd2: c <= in_data;
              default: begin
                d         <= in_data;
                state     <= HOLD;
                out_valid <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          // A presented frame survives clr; only the handoff releases it.
          if (out_ready) begin
            state     <= COLLECT;
            out_valid <= 1'b0;
            cnt       <= 2'd0;
          end
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_sort4_collector.sv
// tb/tb_sort4_collector.sv - randomized bench for sort4_collector against a frame-queue model
// Define SORT4_DBUF_EN for both files to exercise the double-buffered build.
module tb_sort4_collector;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid;
  logic [3:0] a, b, c, d;
  logic [1:0] cnt;

  sort4_collector dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .d(d), .cnt(cnt)
  );

  always #5 clk = ~clk;

`ifdef SORT4_DBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  int tests = 0;
  int fails = 0;
  int accepts = 0;
  int ready_low = 0;
  logic [15:0] pend[$];
  logic [3:0]  part[$];

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: frames waiting for handoff (at most CAP) plus the partial frame being assembled.
  task automatic step();
    bit exp_rdy, acc, ho;
    #1;
    exp_rdy = !clr && (pend.size() < CAP);
    chk("in_ready", 16'(in_ready), 16'(exp_rdy));
    chk("out_valid", 16'(out_valid), 16'(pend.size() > 0));
    chk("cnt", 16'(cnt), 16'(part.size()));
    if (pend.size() > 0) chk("frame", {a, b, c, d}, pend[0]);
    if (in_valid && in_ready) accepts++;
    if (!in_ready) ready_low++;
    acc = in_valid && exp_rdy;
    ho  = (pend.size() > 0) && out_ready;
    @(posedge clk);
    if (clr) begin
      part.delete();
      while (pend.size() > 1) void'(pend.pop_back());
    end
    if (ho) void'(pend.pop_front());
    if (acc) begin
      part.push_back(in_data);
      if (part.size() == 4) begin
        pend.push_back({part[0], part[1], part[2], part[3]});
        part.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] dat, input logic r, input logic cl);
    in_valid  = v;
    in_data   = dat;
    out_ready = r;
    clr       = cl;
    step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr      = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_cnt", 16'(cnt), 16'd0);
    chk("rst_data", {a, b, c, d}, 16'h0000);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    pend.delete();
    part.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 4'd0;
    #12;
    chk("init_out_valid", 16'(out_valid), 16'd0);
    chk("init_cnt", 16'(cnt), 16'd0);
    chk("init_data", {a, b, c, d}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // 3,1,2,0 back to back
    drive(1, 4'd3, 1, 0); chk("t1_cnt1", 16'(cnt), 16'd1);
    drive(1, 4'd1, 1, 0); chk("t1_cnt2", 16'(cnt), 16'd2);
    drive(1, 4'd2, 1, 0); chk("t1_cnt3", 16'(cnt), 16'd3);
    drive(1, 4'd0, 1, 0); chk("t1_cnt0", 16'(cnt), 16'd0);
    chk("t1_valid", 16'(out_valid), 16'd1);
    chk("t1_frame", {a, b, c, d}, 16'h3120);
    drive(0, 4'd0, 1, 0);
    chk("t1_valid_drop", 16'(out_valid), 16'd0);

    // Held frame under backpressure
    for (int i = 0; i < 4; i++) drive(1, 4'd5, 0, 0);
    accepts = 0;
    for (int i = 0; i < 10; i++) drive(1, 4'($urandom_range(0, 15)), 0, 0);
    chk("t2_accepts", 16'(accepts), (CAP == 2) ? 16'd4 : 16'd0);
    chk("t2_valid", 16'(out_valid), 16'd1);
    chk("t2_frame", {a, b, c, d}, 16'h5555);
    chk("t2_ready", 16'(in_ready), 16'd0);
    for (int i = 0; i < 3; i++) drive(0, 4'd0, 1, 0);

    // clr discards partial frame and blocks the concurrent sample
    drive(1, 4'd9, 0, 0);
    drive(1, 4'd8, 0, 0);
    in_valid = 1'b1; in_data = 4'hF; clr = 1'b1; out_ready = 1'b0;
    #1 chk("t3_clr_ready", 16'(in_ready), 16'd0);
    step();
    drive(1, 4'd7, 0, 0);
    drive(1, 4'd6, 0, 0);
    drive(1, 4'd5, 0, 0);
    drive(1, 4'd4, 0, 0);
    chk("t3_frame", {a, b, c, d}, 16'h7654);
    chk("t3_valid", 16'(out_valid), 16'd1);
    drive(0, 4'd0, 1, 0);

    // Async reset with a partial frame, then with a presented frame
    drive(1, 4'd2, 1, 0);
    drive(1, 4'd3, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 4'd9, 0, 0);
    do_reset();
    drive(1, 4'd1, 0, 0);
    drive(1, 4'd2, 0, 0);
    drive(1, 4'd3, 0, 0);
    drive(1, 4'd4, 0, 0);
    chk("t4_frame", {a, b, c, d}, 16'h1234);

    // Continuous stream with out_ready held high
    do_reset();
    ready_low = 0;
    for (int i = 0; i < 20; i++) drive(1, 4'(i), 1, 0);
    chk("t5_ready_gaps", 16'(ready_low), (CAP == 2) ? 16'd0 : 16'd4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
